// File: rtl/beamformer_pkg.sv
// Shared types and width constants for the delay-and-sum beamformer.
// The widths below describe the default 4-channel, 8-bit, 16-deep configuration.
package beamformer_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SAMPLE_BITS = 8;
    localparam int DEF_DEPTH       = 16;

    localparam int CH_W     = $clog2(DEF_NUM_CH);
    localparam int DLY_W    = $clog2(DEF_DEPTH);
    localparam int OUT_BITS = DEF_SAMPLE_BITS + CH_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/sample_ring_buffer.sv
// Per-channel sample history: one synchronous write port and a combinational read by index.
// Reset clears every entry, so slots that have not been written yet read as zero.
module sample_ring_buffer #(
    parameter  int SAMPLE_BITS = 8,
    parameter  int DEPTH       = 16,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic signed [SAMPLE_BITS-1:0] wr_data,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic signed [SAMPLE_BITS-1:0] rd_data
);

    logic signed [SAMPLE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: stores each accepted frame, then sums one delayed sample
// per channel over NUM_CH cycles and holds the result until the sink takes it.
module delay_sum_beamformer #(
    parameter  int NUM_CH      = 4,
    parameter  int SAMPLE_BITS = 8,
    parameter  int DEPTH       = 16,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int DLY_W       = $clog2(DEPTH),
    localparam int OUT_BITS    = SAMPLE_BITS + CH_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*SAMPLE_BITS-1:0] in_data,
    input  logic                          cfg_we,
    input  logic [CH_W-1:0]               cfg_ch,
    input  logic [DLY_W-1:0]              cfg_delay,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_BITS-1:0]    out_data
);
    import beamformer_pkg::*;

    state_t state, next_state;

    logic [DLY_W-1:0]              wr_ptr;
    logic [DLY_W-1:0]              cur_ptr;
    logic [CH_W-1:0]               ch_idx;
    logic signed [OUT_BITS-1:0]    acc;
    logic [DLY_W-1:0]              dly_reg  [NUM_CH];
    logic [DLY_W-1:0]              dly_snap [NUM_CH];
    logic signed [SAMPLE_BITS-1:0] rd_data  [NUM_CH];
    logic signed [SAMPLE_BITS-1:0] sel_sample;
    logic                          accept;
    logic                          last_ch;

    assign accept     = in_valid && in_ready;
    assign last_ch    = (ch_idx == CH_W'(NUM_CH - 1));
    assign sel_sample = rd_data[ch_idx];
    assign out_data   = acc;

    // Read index wraps naturally because DEPTH is a power of two.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ring
        sample_ring_buffer #(
            .SAMPLE_BITS (SAMPLE_BITS),
            .DEPTH       (DEPTH)
        ) u_ring (
            .clk     (clk),
            .reset   (reset),
            .we      (accept),
            .wr_idx  (wr_ptr),
            .wr_data (in_data[c*SAMPLE_BITS +: SAMPLE_BITS]),
            .rd_idx  (cur_ptr - dly_snap[c]),
            .rd_data (rd_data[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (last_ch) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Delays are snapshotted at accept, so a config write only affects later frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            cur_ptr <= '0;
            ch_idx  <= '0;
            acc     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                dly_reg[c]  <= '0;
                dly_snap[c] <= '0;
            end
        end else begin
            if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
                dly_reg[cfg_ch] <= cfg_delay;
            end
            if (accept) begin
                cur_ptr <= wr_ptr;
                wr_ptr  <= wr_ptr + 1'b1;
                acc     <= '0;
                ch_idx  <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    dly_snap[c] <= dly_reg[c];
                end
            end else if (state == ACCUM) begin
                acc    <= acc + {{CH_W{sel_sample[SAMPLE_BITS-1]}}, sel_sample};
                ch_idx <= ch_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer at 4 channels, 8-bit samples, depth 16.
module tb_delay_sum_beamformer;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [3:0]        cfg_delay;
    logic              out_valid;
    logic              out_ready;
    logic signed [9:0] out_data;

    int total_count = 0;
    int bad_count   = 0;

    delay_sum_beamformer #(
        .NUM_CH      (4),
        .SAMPLE_BITS (8),
        .DEPTH       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] want);
        total_count++;
        if (got !== want) begin
            bad_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyConfig(input int ch, input int dly);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_delay = 4'(dly);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // One frame through the handshake; checks readiness, latency and the sum.
    task automatic applyStimulus(input string tag, input int s0, input int s1,
                                 input int s2, input int s3, input int want);
        int waited;
        int lat;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        in_data  = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 4);
        checkOutput({tag, "_data"}, out_data, want);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_delay = '0;
        out_ready = 1'b1;

        doReset();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);

        applyStimulus("f1234", 1, 2, 3, 4, 10);
        @(posedge clk);
        #1;
        checkOutput("ready_after_hs", in_ready, 1);
        checkOutput("valid_after_hs", out_valid, 0);
        applyStimulus("fneg", -128, -128, -128, -128, -512);
        applyStimulus("fmix", 127, -1, 0, 1, 127);

        // Channel 1 delayed by two frames.
        doReset();
        applyConfig(1, 2);
        applyStimulus("d2_a", 0, 10, 0, 0, 0);
        applyStimulus("d2_b", 0, 20, 0, 0, 0);
        applyStimulus("d2_c", 0, 30, 0, 0, 10);

        // Maximum delay on channel 0 across a write-pointer wrap.
        doReset();
        applyConfig(0, 15);
        for (int k = 0; k < 20; k++) begin
            applyStimulus("wrap", k, 0, 0, 0, (k < 15) ? 0 : k - 15);
        end

        // Back-pressure with a pending frame and a delay write while holding.
        doReset();
        out_ready = 1'b0;
        applyStimulus("holdA", 1, 1, 1, 1, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_data  = {4{8'd50}};
            in_valid = 1'b1;
            if (i == 1) begin
                cfg_we    = 1'b1;
                cfg_ch    = 2'd2;
                cfg_delay = 4'd3;
            end
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", out_data, 4);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hold_release", out_valid, 0);
        applyStimulus("holdB", 2, 2, 2, 2, 6);
        applyStimulus("holdC", 3, 3, 3, 3, 9);
        applyStimulus("holdD", 4, 4, 4, 4, 13);

        // Reset in the middle of accumulation.
        @(negedge clk);
        in_data  = {4{8'd9}};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_out_valid", out_valid, 0);
        end
        applyStimulus("post_rst", 5, 5, 5, 5, 20);
        applyConfig(1, 15);
        applyConfig(2, 14);
        applyConfig(3, 13);
        applyStimulus("cleared", 5, 5, 5, 5, 5);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
